accel_poll_ctrl: RTL and testbench
==================================

# accel_poll_ctrl

Transaction sequencer sitting directly upstream of the board's 16-bit-command SPI master. It drives the master's transmit-enable and command word, harvests the read byte, and polls the Nexys4 ADXL362 accelerometer X/Y/Z 8-bit registers at a fixed rate. It publishes the three signed samples, a one-cycle valid strobe and a thresholded tilt-direction vector to the game logic.

## Interface
- SAMPLE_PERIOD, 1_000_000, clock cycles between sequence starts (10 ms at 100 MHz)
- TXN_LEN, 52, cycles O_tx_en is held high per SPI transaction (must be ≥ 51)
- GAP_LEN, 8, cycles O_tx_en is held low between transactions (must be ≥ 2)
- THRESH, 32, unsigned tilt magnitude threshold (0..127)

- I_clk  in  1  system clock
- I_rst  in  1  synchronous, active-high reset
- O_tx_en  out  1  SPI master transmit enable
- O_tx_data  out  16  SPI master command word {cmd, addr}
- I_rx_data  in  8  SPI master received byte
- O_x  out  8  signed X sample
- O_y  out  8  signed Y sample
- O_z  out  8  signed Z sample
- O_valid  out  1  one-cycle strobe: O_x/O_y/O_z/O_dir updated
- O_dir  out  4  tilt flags {down, up, left, right}
- O_busy  out  1  high while a sequence is in progress

## Operation
- Read command word = {8'h0B, addr}; axis order X (8'h08), Y (8'h09), Z (8'h0A).
- SPI master contract: read byte is stable on I_rx_data no later than 50 cycles after O_tx_en rises and is cleared when O_tx_en falls; CS is released by the master.
- Period counter runs free 0..SAMPLE_PERIOD-1, wraps, and restarts at 0 on reset. The wrap cycle raises a start tick. A tick arriving while not IDLE is dropped.
- FSM states:
  - IDLE: waits for the start tick, then goes to TXN with axis=X.
  - TXN: O_tx_en=1, O_tx_data = command for the current axis. Counts 0..TXN_LEN-1; on count TXN_LEN-1, captures I_rx_data into the axis slot, then goes to GAP.
  - GAP: O_tx_en=0. Counts 0..GAP_LEN-1, then:
    - if axis was X or Y: advance axis and go to TXN;
    - if axis was Z: go to IDLE.
  - PUBLISH action (on the Z capture edge): O_x/O_y/O_z load from the slots and O_dir is computed from the new values.
- O_tx_data changes only on the edge entering TXN and holds through GAP.
- O_busy = (state != IDLE).
- Direction rules (signed compare, strict):
  - right = x > THRESH
  - left = x < -THRESH
  - up = y > THRESH
  - down = y < -THRESH
  - 8'h80 (-128) counts as left/down.
- Reset, including mid-sequence: all outputs 0, state IDLE, axis X, slots 0, period counter 0.

## Timing
- O_tx_en rises on the edge after the start tick.
- Each TXN lasts exactly TXN_LEN cycles; each GAP lasts exactly GAP_LEN cycles.
- The capture edge is the last edge of TXN, i.e. O_tx_en is still high when I_rx_data is sampled.
- O_valid is high for exactly the one cycle following the Z capture edge. O_x/O_y/O_z/O_dir change on that same edge.
- A sequence occupies 3·(TXN_LEN+GAP_LEN) cycles (180 by default). Consecutive O_valid pulses are spaced SAMPLE_PERIOD cycles apart.
- After reset, the first O_tx_en rise occurs SAMPLE_PERIOD cycles after I_rst deasserts.

## Test plan
- Reset held 5 cycles -> all outputs 0, O_tx_en 0. Release -> first O_tx_en rise exactly SAMPLE_PERIOD cycles later (bench uses SAMPLE_PERIOD=400).
- SPI model returns 0x30, 0xD0, 0x40 -> O_tx_data sequence 0x0B08, 0x0B09, 0x0B0A; each O_tx_en pulse is 52 cycles high with 8 low between; single O_valid; O_x=0x30, O_y=0xD0, O_z=0x40, O_dir=4'b1001.
- Threshold edges with THRESH=32: x=0x20, y=0xE0 -> O_dir=0; x=0x21, y=0xDF -> O_dir=4'b1001; x=0x80, y=0x7F -> O_dir=4'b0110.
- I_rst asserted at TXN count 20 of the Y transaction -> next cycle O_tx_en=0, O_busy=0, O_x keeps reset value 0, no O_valid. Next sequence starts SAMPLE_PERIOD cycles after release.
- Free run for 3 periods with changing model data -> O_valid pulses exactly SAMPLE_PERIOD apart; each pulse carries that sequence's bytes; O_x/O_y/O_z stable between pulses.
- SPI model drives I_rx_data valid only at cycle 50 of TXN -> captured value correct (capture at count 51).

Source files
------------

// File: rtl/accel_poll_ctrl.sv
// Poll sequencer for the ADXL362 over a 16-bit-command SPI master: reads X/Y/Z
// once per sample period and publishes signed samples plus a thresholded tilt vector.
module accel_poll_ctrl #(
  parameter int unsigned SAMPLE_PERIOD = 1_000_000,
  parameter int unsigned TXN_LEN       = 52,
  parameter int unsigned GAP_LEN       = 8,
  parameter int unsigned THRESH        = 32
) (
  input  logic        I_clk,
  input  logic        I_rst,
  output logic        O_tx_en,
  output logic [15:0] O_tx_data,
  input  logic [7:0]  I_rx_data,
  output logic [7:0]  O_x,
  output logic [7:0]  O_y,
  output logic [7:0]  O_z,
  output logic        O_valid,
  output logic [3:0]  O_dir,
  output logic        O_busy
);

  localparam int unsigned PER_W   = (SAMPLE_PERIOD > 1) ? $clog2(SAMPLE_PERIOD) : 1;
  localparam int unsigned CNT_MAX = (TXN_LEN > GAP_LEN) ? TXN_LEN : GAP_LEN;
  localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  localparam logic [PER_W-1:0] PER_LAST = PER_W'(SAMPLE_PERIOD - 1);
  localparam logic [CNT_W-1:0] TXN_LAST = CNT_W'(TXN_LEN - 1);
  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_LEN - 1);

  localparam logic [7:0] CMD_READ = 8'h0B;
  localparam logic [7:0] ADDR_X   = 8'h08;
  localparam logic [7:0] ADDR_Y   = 8'h09;
  localparam logic [7:0] ADDR_Z   = 8'h0A;

  // Nine bits so that -THRESH and -128 are both representable.
  localparam logic signed [8:0] THR_POS = $signed(9'(THRESH));
  localparam logic signed [8:0] THR_NEG = -$signed(9'(THRESH));

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_TXN  = 2'd1,
    S_GAP  = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    AX_X = 2'd0,
    AX_Y = 2'd1,
    AX_Z = 2'd2
  } axis_e;

  function automatic logic [3:0] tilt_dir(input logic [7:0] x, input logic [7:0] y);
    logic signed [8:0] xs;
    logic signed [8:0] ys;
    xs = $signed({x[7], x});
    ys = $signed({y[7], y});
    tilt_dir = {ys < THR_NEG, ys > THR_POS, xs < THR_NEG, xs > THR_POS};
  endfunction

  state_e           state_q, state_d;
  axis_e            axis_q, axis_d;
  logic [PER_W-1:0] per_cnt_q, per_cnt_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       slot_x_q, slot_x_d;
  logic [7:0]       slot_y_q, slot_y_d;
  logic             tx_en_q, tx_en_d;
  logic [15:0]      tx_data_q, tx_data_d;
  logic [7:0]       x_q, x_d;
  logic [7:0]       y_q, y_d;
  logic [7:0]       z_q, z_d;
  logic             valid_q, valid_d;
  logic [3:0]       dir_q, dir_d;
  logic             busy_q, busy_d;
  logic             tick_s;

  // Next-state, counters, capture and publish logic.
  always_comb begin
    state_d   = state_q;
    axis_d    = axis_q;
    cnt_d     = cnt_q;
    slot_x_d  = slot_x_q;
    slot_y_d  = slot_y_q;
    tx_data_d = tx_data_q;
    x_d       = x_q;
    y_d       = y_q;
    z_d       = z_q;
    dir_d     = dir_q;
    valid_d   = 1'b0;

    tick_s = (per_cnt_q == PER_LAST);
    if (tick_s) begin
      per_cnt_d = '0;
    end else begin
      per_cnt_d = per_cnt_q + PER_W'(1);
    end

    case (state_q)
      S_IDLE: begin
        if (tick_s) begin
          state_d   = S_TXN;
          axis_d    = AX_X;
          cnt_d     = '0;
          tx_data_d = {CMD_READ, ADDR_X};
        end else begin
          state_d = S_IDLE;
        end
      end
      S_TXN: begin
        if (cnt_q == TXN_LAST) begin
          state_d = S_GAP;
          cnt_d   = '0;
          case (axis_q)
            AX_X: slot_x_d = I_rx_data;
            AX_Y: slot_y_d = I_rx_data;
            AX_Z: begin
              x_d     = slot_x_q;
              y_d     = slot_y_q;
              z_d     = I_rx_data;
              dir_d   = tilt_dir(slot_x_q, slot_y_q);
              valid_d = 1'b1;
            end
            default: state_d = S_IDLE;
          endcase
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_GAP: begin
        if (cnt_q == GAP_LAST) begin
          cnt_d = '0;
          case (axis_q)
            AX_X: begin
              state_d   = S_TXN;
              axis_d    = AX_Y;
              tx_data_d = {CMD_READ, ADDR_Y};
            end
            AX_Y: begin
              state_d   = S_TXN;
              axis_d    = AX_Z;
              tx_data_d = {CMD_READ, ADDR_Z};
            end
            AX_Z: begin
              state_d = S_IDLE;
              axis_d  = AX_X;
            end
            default: begin
              state_d = S_IDLE;
              axis_d  = AX_X;
            end
          endcase
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        axis_d  = AX_X;
        cnt_d   = '0;
      end
    endcase

    tx_en_d = (state_d == S_TXN);
    busy_d  = (state_d != S_IDLE);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge I_clk) begin
    if (I_rst) begin
      state_q   <= S_IDLE;
      axis_q    <= AX_X;
      per_cnt_q <= '0;
      cnt_q     <= '0;
      slot_x_q  <= 8'h00;
      slot_y_q  <= 8'h00;
      tx_en_q   <= 1'b0;
      tx_data_q <= 16'h0000;
      x_q       <= 8'h00;
      y_q       <= 8'h00;
      z_q       <= 8'h00;
      valid_q   <= 1'b0;
      dir_q     <= 4'h0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      axis_q    <= axis_d;
      per_cnt_q <= per_cnt_d;
      cnt_q     <= cnt_d;
      slot_x_q  <= slot_x_d;
      slot_y_q  <= slot_y_d;
      tx_en_q   <= tx_en_d;
      tx_data_q <= tx_data_d;
      x_q       <= x_d;
      y_q       <= y_d;
      z_q       <= z_d;
      valid_q   <= valid_d;
      dir_q     <= dir_d;
      busy_q    <= busy_d;
    end
  end

  assign O_tx_en   = tx_en_q;
  assign O_tx_data = tx_data_q;
  assign O_x       = x_q;
  assign O_y       = y_q;
  assign O_z       = z_q;
  assign O_valid   = valid_q;
  assign O_dir     = dir_q;
  assign O_busy    = busy_q;

endmodule

// File: tb/tb_accel_poll_ctrl.sv
// Bench for accel_poll_ctrl: timeline model checked every cycle, an SPI slave
// that only presents the byte from TXN cycle 50, and directed literal checks.
module tb_accel_poll_ctrl;

  localparam int SP   = 400;
  localparam int TXN  = 52;
  localparam int GAP  = 8;
  localparam int TH   = 32;
  localparam int PAIR = TXN + GAP;
  localparam int SEQ  = 3 * PAIR;

  logic        I_clk = 1'b0;
  logic        I_rst = 1'b1;
  logic        O_tx_en;
  logic [15:0] O_tx_data;
  logic [7:0]  I_rx_data = 8'h00;
  logic [7:0]  O_x, O_y, O_z;
  logic        O_valid;
  logic [3:0]  O_dir;
  logic        O_busy;

  always #5 I_clk = ~I_clk;

  accel_poll_ctrl #(
    .SAMPLE_PERIOD(SP),
    .TXN_LEN(TXN),
    .GAP_LEN(GAP),
    .THRESH(TH)
  ) dut (
    .I_clk(I_clk),
    .I_rst(I_rst),
    .O_tx_en(O_tx_en),
    .O_tx_data(O_tx_data),
    .I_rx_data(I_rx_data),
    .O_x(O_x),
    .O_y(O_y),
    .O_z(O_z),
    .O_valid(O_valid),
    .O_dir(O_dir),
    .O_busy(O_busy)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  logic [7:0] cur_x = 8'h30;
  logic [7:0] cur_y = 8'hD0;
  logic [7:0] cur_z = 8'h40;

  function automatic logic [3:0] tilt(input logic [7:0] x, input logic [7:0] y);
    int sx, sy;
    sx = int'($signed(x));
    sy = int'($signed(y));
    return {sy < -TH, sy > TH, sx < -TH, sx > TH};
  endfunction

  // Timeline model: n = edges since the last reset edge; sequences start at every
  // multiple of SP (excluding 0) and occupy SEQ cycles.
  int          n = 0;
  bit          chk_en = 1'b0;
  logic [15:0] m_txd = 16'h0000;
  logic [7:0]  m_x = 8'h00, m_y = 8'h00, m_z = 8'h00;
  logic [3:0]  m_dir = 4'h0;

  always @(posedge I_clk) begin : model
    int k, o;
    cyc++;
    if (I_rst) begin
      n = 0; m_txd = 16'h0000; m_x = 8'h00; m_y = 8'h00; m_z = 8'h00; m_dir = 4'h0;
      chk_en = 1'b1;
    end else begin
      n++;
      k = n / SP;
      o = n % SP;
      if (k >= 1 && o < SEQ) begin
        if (o % PAIR == 0) m_txd = 16'h0B08 + 16'(o / PAIR);
        if (o == 2 * PAIR + TXN) begin
          m_x = cur_x; m_y = cur_y; m_z = cur_z; m_dir = tilt(cur_x, cur_y);
        end
      end
    end
  end

  always @(negedge I_clk) begin : compare
    int k, o;
    logic e_en, e_busy, e_val;
    logic [46:0] act, exp;
    if (chk_en) begin
      k = n / SP;
      o = n % SP;
      e_busy = (k >= 1) && (o < SEQ);
      e_en   = e_busy && ((o % PAIR) < TXN);
      e_val  = (k >= 1) && (o == 2 * PAIR + TXN);
      exp = {e_en, m_txd, m_x, m_y, m_z, e_val, m_dir, e_busy};
      act = {O_tx_en, O_tx_data, O_x, O_y, O_z, O_valid, O_dir, O_busy};
      checks++;
      if (act !== exp) begin
        errors++;
        $display("FAIL per_cycle n=%0d got=%h want=%h", n, act, exp);
      end
    end
  end

  // SPI slave: garbage until TXN cycle 50, then the addressed byte, 0 when idle.
  int rc = 0;
  always @(posedge I_clk) begin : spi
    logic [7:0] b;
    #1;
    if (!O_tx_en) begin
      rc = 0;
      I_rx_data = 8'h00;
    end else begin
      rc++;
      case (O_tx_data[7:0])
        8'h08:   b = cur_x;
        8'h09:   b = cur_y;
        8'h0A:   b = cur_z;
        default: b = 8'h5A;
      endcase
      I_rx_data = (rc - 1 >= 50) ? b : ~b;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h want=%h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s timeout", name);
  endtask

  task automatic wait_rise(input string name, output int cnt);
    cnt = 0;
    do begin
      @(posedge I_clk); #1; cnt++;
    end while (!O_tx_en && cnt < 3 * SP);
    if (!O_tx_en) timeout(name);
  endtask

  task automatic wait_valid(input string name);
    int c;
    c = 0;
    do begin
      @(posedge I_clk); #1; c++;
    end while (!O_valid && c < 3 * SP);
    if (!O_valid) timeout(name);
  endtask

  typedef struct packed { logic [7:0] x, y, z; logic [3:0] dir; } vec_t;

  initial begin
    int   cnt, hi, lo, prev;
    vec_t thr[3];
    vec_t fr[3];
    thr[0] = '{x: 8'h20, y: 8'hE0, z: 8'h11, dir: 4'b0000};
    thr[1] = '{x: 8'h21, y: 8'hDF, z: 8'h22, dir: 4'b1001};
    thr[2] = '{x: 8'h80, y: 8'h7F, z: 8'h33, dir: 4'b0110};
    fr[0]  = '{x: 8'h05, y: 8'hFB, z: 8'h7E, dir: 4'b0000};
    fr[1]  = '{x: 8'hC0, y: 8'h41, z: 8'h81, dir: 4'b0110};
    fr[2]  = '{x: 8'h7F, y: 8'h80, z: 8'h01, dir: 4'b1001};

    // Reset held 5 cycles.
    repeat (5) @(negedge I_clk);
    chk("rst_tx_en", 32'(O_tx_en), 32'd0);
    chk("rst_tx_data", 32'(O_tx_data), 32'd0);
    chk("rst_x", 32'(O_x), 32'd0);
    chk("rst_valid", 32'(O_valid), 32'd0);
    chk("rst_dir", 32'(O_dir), 32'd0);
    chk("rst_busy", 32'(O_busy), 32'd0);
    I_rst = 1'b0;
    wait_rise("first_rise", cnt);
    chk("first_rise_delay", 32'(cnt), 32'(SP));

    // Basic sequence: command words, pulse shapes, publish.
    for (int t = 0; t < 3; t++) begin
      chk("tx_data", 32'(O_tx_data), 32'(16'h0B08 + 16'(t)));
      hi = 0;
      do begin @(posedge I_clk); #1; hi++; end while (O_tx_en && hi < 200);
      chk("tx_en_high", 32'(hi), 32'd52);
      if (t < 2) begin
        lo = 0;
        do begin @(posedge I_clk); #1; lo++; end while (!O_tx_en && lo < 200);
        chk("tx_en_low", 32'(lo), 32'd8);
      end
    end
    chk("valid", 32'(O_valid), 32'd1);
    chk("x", 32'(O_x), 32'h30);
    chk("y", 32'(O_y), 32'hD0);
    chk("z", 32'(O_z), 32'h40);
    chk("dir", 32'(O_dir), 32'b1001);

    // Threshold edges.
    for (int i = 0; i < 3; i++) begin
      @(negedge I_clk);
      cur_x = thr[i].x; cur_y = thr[i].y; cur_z = thr[i].z;
      wait_valid("thr_valid");
      chk("thr_x", 32'(O_x), 32'(thr[i].x));
      chk("thr_dir", 32'(O_dir), 32'(thr[i].dir));
    end

    // Reset at count 20 of the Y transaction.
    @(negedge I_clk);
    cur_x = fr[0].x; cur_y = fr[0].y; cur_z = fr[0].z;
    cnt = 0;
    do begin @(posedge I_clk); #1; cnt++; end
    while (!(O_tx_en && O_tx_data == 16'h0B09) && cnt < 3 * SP);
    if (!(O_tx_en && O_tx_data == 16'h0B09)) timeout("y_txn");
    repeat (20) @(posedge I_clk);
    #1 I_rst = 1'b1;
    @(posedge I_clk); #1;
    chk("mid_rst_tx_en", 32'(O_tx_en), 32'd0);
    chk("mid_rst_busy", 32'(O_busy), 32'd0);
    chk("mid_rst_x", 32'(O_x), 32'd0);
    chk("mid_rst_valid", 32'(O_valid), 32'd0);
    @(negedge I_clk);
    I_rst = 1'b0;
    wait_rise("rise_after_rst", cnt);
    chk("rise_after_rst_delay", 32'(cnt), 32'(SP));

    // Free run over three periods with changing data.
    prev = 0;
    for (int i = 0; i < 3; i++) begin
      wait_valid("fr_valid");
      chk("fr_x", 32'(O_x), 32'(fr[i].x));
      chk("fr_y", 32'(O_y), 32'(fr[i].y));
      chk("fr_z", 32'(O_z), 32'(fr[i].z));
      chk("fr_dir", 32'(O_dir), 32'(fr[i].dir));
      if (i > 0) chk("fr_spacing", 32'(cyc - prev), 32'(SP));
      prev = cyc;
      if (i < 2) begin
        @(negedge I_clk);
        cur_x = fr[i+1].x; cur_y = fr[i+1].y; cur_z = fr[i+1].z;
      end
    end
    repeat (20) @(posedge I_clk);
    @(negedge I_clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
